load_wb_unit: RTL and testbench
===============================

LOAD_WB_UNIT -- requirements
Module: load_wb_unit

Interface
REQ-001 Parameter DW, default 64, data width.
REQ-002 Parameter AW, default 5, register-address width.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rstn  in  1  reset, synchronous, active-low.
REQ-005 issue_valid  in  1  write-back request present.
REQ-006 issue_ready  out  1  unit accepts request (IDLE only).
REQ-007 issue_kind  in  2  00 ALU, 01 PC, 10 LOAD, 11 reserved.
REQ-008 issue_rd  in  AW  destination register.
REQ-009 issue_alu_data  in  DW  ALU result.
REQ-010 issue_pc_data  in  DW  pc+4 value.
REQ-011 issue_addr  in  DW  load byte address.
REQ-012 issue_funct3  in  3  load width/sign code.
REQ-013 mem_req_valid  out  1  memory read request.
REQ-014 mem_req_ready  in  1  memory accepts request.
REQ-015 mem_req_addr  out  DW  issue_addr with bits [2:0] cleared.
REQ-016 mem_rsp_valid  in  1  read data valid.
REQ-017 mem_rsp_data  in  DW  aligned 8-byte read data.
REQ-018 wb_en, wb_load, wb_pc, wb_alu  out  1 each  write-back strobe and one-hot source select.
REQ-019 wb_addr  out  AW; load_data, pc_data, alu_data  out  DW each: write-back payload.
REQ-020 busy  out  1  state is not IDLE.
REQ-021 err  out  1  one-cycle pulse: misaligned, illegal funct3 or reserved kind.

Function
REQ-022 FSM states: IDLE, REQ, WAIT, WB; all outputs registered.
REQ-023 IDLE: issue_ready=1; on issue_valid, capture all issue fields.
REQ-024 ALU/PC kind: IDLE->WB next cycle; write-back occurs one cycle after acceptance.
REQ-025 LOAD kind, legal and aligned: IDLE->REQ.
REQ-026 REQ: mem_req_valid=1, address stable; on mem_req_ready go to WAIT.
REQ-027 WAIT: on mem_rsp_valid, extract and extend data, then go to WB.
REQ-028 mem_rsp_valid is ignored outside WAIT, including in the cycle the request is accepted.
REQ-029 Offset = addr[2:0]; the field is taken from mem_rsp_data[8*offset +: size].
REQ-030 funct3 000 LB, 001 LH, 010 LW, 011 LD sign-extend to DW.
REQ-031 funct3 100 LBU, 101 LHU, 110 LWU zero-extend to DW.
REQ-032 funct3 111 is illegal.
REQ-033 Misaligned: LH/LHU with odd offset; LW/LWU with offset[1:0]!=0; LD with offset!=0.
REQ-034 Illegal, misaligned or kind 11 in IDLE: pulse err for one cycle, stay IDLE, issue no memory request and no write-back.
REQ-035 WB lasts exactly one cycle.
- Exactly one of wb_load/wb_pc/wb_alu is 1.
- wb_en=1 unless wb_addr==0; then wb_en=0.
- Return to IDLE the next cycle.
REQ-036 Outside WB, wb_en and all selects are 0; payloads hold their last value.
REQ-037 New requests are accepted only in IDLE; one request is in flight at a time.

Reset
REQ-038 When rstn=0 at a clock edge:
- state goes to IDLE.
- wb_en, wb_load, wb_pc, wb_alu, mem_req_valid, err and busy go to 0.
- wb_addr, load_data, pc_data, alu_data and mem_req_addr go to 0.
REQ-039 Reset in REQ/WAIT abandons the transaction; a later stale mem_rsp_valid in IDLE is ignored.

Structure
REQ-040 A shared package holds:
- issue_kind encodings.
- funct3 load codes.
- FSM state encoding.
REQ-041 Extract/extend logic lives in sub-module load_align (combinational: offset, funct3, data -> DW result).

Verification
REQ-042 ALU issue: rd=5, alu=0x1234 -> next cycle wb_en=1, wb_alu=1, wb_addr=5, alu_data=0x1234.
REQ-043 LB, addr=0x1003, rsp=0x0000_0000_8000_0000, mem_req_ready delayed 2 cycles -> mem_req_addr=0x1000; load_data=0xFFFF_FFFF_FFFF_FF80.
REQ-044 LWU, addr=0x2004, rsp=0xDEADBEEF_00000000 -> load_data=0x0000_0000_DEAD_BEEF; wb_load=1.
REQ-045 LD, addr=0x3004 -> err pulses once; no mem_req_valid; no wb_en; issue_ready stays 1.
REQ-046 PC issue with rd=0 -> WB cycle with wb_pc=1, wb_en=0.
REQ-047 Reset asserted in WAIT, then mem_rsp_valid=1 -> no write-back; all outputs at reset values.

Source files
------------

// File: rtl/load_wb_unit_pkg.sv
// Shared encodings for the load/write-back unit: issue kinds, load funct3 codes,
// FSM states and the load legality check.
package load_wb_unit_pkg;

    typedef enum logic [1:0] {
        KIND_ALU  = 2'b00,
        KIND_PC   = 2'b01,
        KIND_LOAD = 2'b10,
        KIND_RSVD = 2'b11
    } kind_e;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LD  = 3'b011,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101,
        F3_LWU = 3'b110,
        F3_ILL = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_WB   = 2'b11
    } state_e;

    // True when the load cannot be issued: illegal code or offset not a multiple of the size.
    function automatic logic load_is_bad(input logic [2:0] funct3, input logic [2:0] offset);
        logic bad;
        case (funct3)
            F3_LH, F3_LHU: bad = offset[0];
            F3_LW, F3_LWU: bad = (offset[1:0] != 2'b00);
            F3_LD:         bad = (offset != 3'b000);
            F3_ILL:        bad = 1'b1;
            default:       bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_wb_unit_if.sv
// Issue, memory-read and write-back signals of the load/write-back unit.
// The unit uses the slave view; whoever drives requests and memory uses master.
interface load_wb_unit_if #(
    parameter int DW = 64,
    parameter int AW = 5
);
    logic          issue_valid;
    logic          issue_ready;
    logic [1:0]    issue_kind;
    logic [AW-1:0] issue_rd;
    logic [DW-1:0] issue_alu_data;
    logic [DW-1:0] issue_pc_data;
    logic [DW-1:0] issue_addr;
    logic [2:0]    issue_funct3;

    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [DW-1:0] mem_req_addr;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;

    logic          wb_en;
    logic          wb_load;
    logic          wb_pc;
    logic          wb_alu;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] load_data;
    logic [DW-1:0] pc_data;
    logic [DW-1:0] alu_data;

    logic          busy;
    logic          err;

    modport slave (
        input  issue_valid, issue_kind, issue_rd, issue_alu_data, issue_pc_data,
               issue_addr, issue_funct3, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output issue_ready, mem_req_valid, mem_req_addr, wb_en, wb_load, wb_pc, wb_alu,
               wb_addr, load_data, pc_data, alu_data, busy, err
    );

    modport master (
        output issue_valid, issue_kind, issue_rd, issue_alu_data, issue_pc_data,
               issue_addr, issue_funct3, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  issue_ready, mem_req_valid, mem_req_addr, wb_en, wb_load, wb_pc, wb_alu,
               wb_addr, load_data, pc_data, alu_data, busy, err
    );

endinterface

// File: rtl/load_wb_unit_load_align.sv
// Picks the addressed byte/half/word/double out of an aligned 8-byte read
// and sign- or zero-extends it to DW.
module load_align
    import load_wb_unit_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic [2:0]    offset_i,
    input  logic [2:0]    funct3_i,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] result_o
);

    logic [DW-1:0] shifted;
    logic [DW-1:0] mask;
    logic          sign;

    always_comb begin
        shifted = data_i >> {offset_i, 3'b000};
        mask    = '0;
        sign    = 1'b0;
        case (funct3_i)
            F3_LB:  begin mask = DW'(8'hFF);        sign = shifted[7];  end
            F3_LH:  begin mask = DW'(16'hFFFF);     sign = shifted[15]; end
            F3_LW:  begin mask = DW'(32'hFFFF_FFFF); sign = shifted[31]; end
            F3_LD:  begin mask = '1;                sign = 1'b0;        end
            F3_LBU: begin mask = DW'(8'hFF);        sign = 1'b0;        end
            F3_LHU: begin mask = DW'(16'hFFFF);     sign = 1'b0;        end
            F3_LWU: begin mask = DW'(32'hFFFF_FFFF); sign = 1'b0;        end
            default: begin mask = '0;               sign = 1'b0;        end
        endcase
        result_o = (shifted & mask) | (~mask & {DW{sign}});
    end

endmodule

// File: rtl/load_wb_unit.sv
// Write-back sequencer: ALU/PC results go straight to write-back, loads make one
// aligned memory read first. All outputs are registered.
//
//   state   | meaning
//   IDLE    | ready for a new request; bad requests pulse err here
//   REQ     | memory read request presented, waiting for mem_req_ready
//   WAIT    | waiting for mem_rsp_valid
//   WB      | one-cycle write-back strobe
module load_wb_unit
    import load_wb_unit_pkg::*;
#(
    parameter int DW = 64,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rstn,
    load_wb_unit_if.slave bus_if
);

    state_e        state_q, state_d;
    logic          issue_ready_q, issue_ready_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic          mem_req_valid_q, mem_req_valid_d;
    logic [DW-1:0] mem_req_addr_q, mem_req_addr_d;
    logic          wb_en_q, wb_en_d;
    logic          wb_load_q, wb_load_d;
    logic          wb_pc_q, wb_pc_d;
    logic          wb_alu_q, wb_alu_d;
    logic [AW-1:0] wb_addr_q, wb_addr_d;
    logic [DW-1:0] load_data_q, load_data_d;
    logic [DW-1:0] pc_data_q, pc_data_d;
    logic [DW-1:0] alu_data_q, alu_data_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [2:0]    offset_q, offset_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [DW-1:0] aligned;

    load_align #(.DW(DW)) u_align (
        .offset_i (offset_q),
        .funct3_i (funct3_q),
        .data_i   (bus_if.mem_rsp_data),
        .result_o (aligned)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q         <= ST_IDLE;
            issue_ready_q   <= 1'b1;
            busy_q          <= 1'b0;
            err_q           <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            wb_en_q         <= 1'b0;
            wb_load_q       <= 1'b0;
            wb_pc_q         <= 1'b0;
            wb_alu_q        <= 1'b0;
            wb_addr_q       <= '0;
            load_data_q     <= '0;
            pc_data_q       <= '0;
            alu_data_q      <= '0;
            rd_q            <= '0;
            offset_q        <= '0;
            funct3_q        <= '0;
        end else begin
            state_q         <= state_d;
            issue_ready_q   <= issue_ready_d;
            busy_q          <= busy_d;
            err_q           <= err_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
            wb_en_q         <= wb_en_d;
            wb_load_q       <= wb_load_d;
            wb_pc_q         <= wb_pc_d;
            wb_alu_q        <= wb_alu_d;
            wb_addr_q       <= wb_addr_d;
            load_data_q     <= load_data_d;
            pc_data_q       <= pc_data_d;
            alu_data_q      <= alu_data_d;
            rd_q            <= rd_d;
            offset_q        <= offset_d;
            funct3_q        <= funct3_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        err_d          = 1'b0;
        wb_en_d        = 1'b0;
        wb_load_d      = 1'b0;
        wb_pc_d        = 1'b0;
        wb_alu_d       = 1'b0;
        wb_addr_d      = wb_addr_q;
        load_data_d    = load_data_q;
        pc_data_d      = pc_data_q;
        alu_data_d     = alu_data_q;
        mem_req_addr_d = mem_req_addr_q;
        rd_d           = rd_q;
        offset_d       = offset_q;
        funct3_d       = funct3_q;

        case (state_q)
            ST_IDLE: begin
                if (bus_if.issue_valid) begin
                    case (bus_if.issue_kind)
                        KIND_ALU: begin
                            state_d    = ST_WB;
                            wb_alu_d   = 1'b1;
                            wb_en_d    = (bus_if.issue_rd != '0);
                            wb_addr_d  = bus_if.issue_rd;
                            alu_data_d = bus_if.issue_alu_data;
                        end
                        KIND_PC: begin
                            state_d   = ST_WB;
                            wb_pc_d   = 1'b1;
                            wb_en_d   = (bus_if.issue_rd != '0);
                            wb_addr_d = bus_if.issue_rd;
                            pc_data_d = bus_if.issue_pc_data;
                        end
                        KIND_LOAD: begin
                            if (load_is_bad(bus_if.issue_funct3, bus_if.issue_addr[2:0])) begin
                                err_d = 1'b1;
                            end else begin
                                state_d        = ST_REQ;
                                rd_d           = bus_if.issue_rd;
                                offset_d       = bus_if.issue_addr[2:0];
                                funct3_d       = bus_if.issue_funct3;
                                mem_req_addr_d = {bus_if.issue_addr[DW-1:3], 3'b000};
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            ST_REQ: begin
                if (bus_if.mem_req_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus_if.mem_rsp_valid) begin
                    state_d     = ST_WB;
                    wb_load_d   = 1'b1;
                    wb_en_d     = (rd_q != '0);
                    wb_addr_d   = rd_q;
                    load_data_d = aligned;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        issue_ready_d   = (state_d == ST_IDLE);
        busy_d          = (state_d != ST_IDLE);
        mem_req_valid_d = (state_d == ST_REQ);
    end

    assign bus_if.issue_ready   = issue_ready_q;
    assign bus_if.busy          = busy_q;
    assign bus_if.err           = err_q;
    assign bus_if.mem_req_valid = mem_req_valid_q;
    assign bus_if.mem_req_addr  = mem_req_addr_q;
    assign bus_if.wb_en         = wb_en_q;
    assign bus_if.wb_load       = wb_load_q;
    assign bus_if.wb_pc         = wb_pc_q;
    assign bus_if.wb_alu        = wb_alu_q;
    assign bus_if.wb_addr       = wb_addr_q;
    assign bus_if.load_data     = load_data_q;
    assign bus_if.pc_data       = pc_data_q;
    assign bus_if.alu_data      = alu_data_q;

endmodule

// File: tb/tb_load_wb_unit.sv
// Bench for load_wb_unit: directed scenarios plus randomized requests checked
// against a transaction-level model of the write-back rules.
module tb_load_wb_unit;
    localparam int DW = 64;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    load_wb_unit_if #(.DW(DW), .AW(AW)) bus ();

    load_wb_unit #(.DW(DW), .AW(AW)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .bus_if (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int            obs_err, obs_req_cycles, obs_wb_cnt;
    logic          obs_addr_stable, obs_ready_low, obs_stray, obs_timeout, obs_onehot_bad;
    logic [DW-1:0] obs_req_addr, obs_load_data, obs_pc_data, obs_alu_data;
    logic [AW-1:0] obs_wb_addr;
    logic          obs_wb_en, obs_wb_load, obs_wb_pc, obs_wb_alu;

    function automatic int model_size(input logic [2:0] f3);
        logic [1:0] sz;
        sz = f3[1:0];
        return 1 << sz;
    endfunction

    function automatic bit model_bad(input logic [1:0] kind, input logic [2:0] f3, input logic [2:0] off);
        if (kind == 2'b11) return 1'b1;
        if (kind != 2'b10) return 1'b0;
        if (f3 == 3'b111) return 1'b1;
        return (int'(off) % model_size(f3)) != 0;
    endfunction

    function automatic logic [DW-1:0] model_load(input logic [2:0] f3, input logic [2:0] off, input logic [63:0] data);
        logic [DW-1:0] r;
        int nb, o;
        r  = '0;
        nb = model_size(f3);
        o  = int'(off);
        for (int k = 0; k < nb; k++)
            if (o + k < 8) r[8*k +: 8] = data[8*(o+k) +: 8];
        if (!f3[2] && r[8*nb-1])
            for (int k = nb; k < DW/8; k++) r[8*k +: 8] = 8'hFF;
        return r;
    endfunction

    task automatic idle_inputs();
        bus.issue_valid    = 1'b0;
        bus.issue_kind     = 2'b00;
        bus.issue_rd       = '0;
        bus.issue_alu_data = '0;
        bus.issue_pc_data  = '0;
        bus.issue_addr     = '0;
        bus.issue_funct3   = 3'b000;
        bus.mem_req_ready  = 1'b0;
        bus.mem_rsp_valid  = 1'b0;
        bus.mem_rsp_data   = '0;
    endtask

    // Issues one request, plays the memory side and records what the unit did.
    task automatic run_txn(input logic [1:0] kind, input logic [AW-1:0] rd, input logic [DW-1:0] alu,
                           input logic [DW-1:0] pc, input logic [DW-1:0] addr, input logic [2:0] f3,
                           input int req_delay, input int rsp_delay, input logic [DW-1:0] rsp);
        int req_wait, rsp_wait;
        bit accepted, responded, done;
        req_wait = 0; rsp_wait = 0; accepted = 0; responded = 0; done = 0;
        obs_err = 0; obs_req_cycles = 0; obs_wb_cnt = 0;
        obs_addr_stable = 1; obs_ready_low = 0; obs_stray = 0; obs_onehot_bad = 0;
        obs_req_addr = '0; obs_wb_en = 0; obs_wb_load = 0; obs_wb_pc = 0; obs_wb_alu = 0;
        @(negedge clk);
        bus.issue_valid = 1'b1; bus.issue_kind = kind; bus.issue_rd = rd;
        bus.issue_alu_data = alu; bus.issue_pc_data = pc; bus.issue_addr = addr; bus.issue_funct3 = f3;
        @(negedge clk);
        bus.issue_valid = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (cyc != 0) @(negedge clk);
            bus.mem_req_ready = 1'b0;
            bus.mem_rsp_valid = 1'b0;
            if (bus.err) obs_err++;
            if (!bus.issue_ready && obs_wb_cnt == 0 && obs_req_cycles == 0) obs_ready_low = 1;
            if (bus.mem_req_valid) begin
                if (obs_req_cycles == 0) obs_req_addr = bus.mem_req_addr;
                else if (bus.mem_req_addr !== obs_req_addr) obs_addr_stable = 0;
                obs_req_cycles++;
                if (req_wait == req_delay) begin
                    bus.mem_req_ready = 1'b1;
                    bus.mem_rsp_valid = 1'b1;
                    bus.mem_rsp_data  = ~rsp;
                    accepted = 1;
                end else req_wait++;
            end else if (accepted && !responded) begin
                if (rsp_wait == rsp_delay) begin
                    bus.mem_rsp_valid = 1'b1;
                    bus.mem_rsp_data  = rsp;
                    responded = 1;
                end else rsp_wait++;
            end
            if (bus.wb_en | bus.wb_load | bus.wb_pc | bus.wb_alu) begin
                obs_wb_cnt++;
                obs_wb_en = bus.wb_en; obs_wb_load = bus.wb_load; obs_wb_pc = bus.wb_pc; obs_wb_alu = bus.wb_alu;
                obs_wb_addr = bus.wb_addr; obs_load_data = bus.load_data;
                obs_pc_data = bus.pc_data; obs_alu_data = bus.alu_data;
                if ($countones({bus.wb_load, bus.wb_pc, bus.wb_alu}) != 1) obs_onehot_bad = 1;
            end else if (bus.issue_ready && (obs_wb_cnt > 0 || obs_err > 0)) begin
                done = 1;
            end
        end
        obs_timeout = !done;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        @(negedge clk);
        obs_stray = bus.err | bus.mem_req_valid | bus.wb_en | bus.wb_load | bus.wb_pc | bus.wb_alu | !bus.issue_ready;
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0;
        bus.issue_valid = 1'b1; bus.issue_kind = 2'b00; bus.issue_rd = 5'd3; bus.issue_alu_data = 64'h55;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.wb_en, bus.wb_load, bus.wb_pc, bus.wb_alu, bus.mem_req_valid, bus.err, bus.busy} !== 7'b0) begin
            n_fail++; $display("FAIL reset_strobes: got %b want 0000000",
                {bus.wb_en, bus.wb_load, bus.wb_pc, bus.wb_alu, bus.mem_req_valid, bus.err, bus.busy});
        end
        n_checks++;
        if ({bus.wb_addr, bus.load_data, bus.pc_data, bus.alu_data, bus.mem_req_addr} !== '0) begin
            n_fail++; $display("FAIL reset_payloads: wb_addr=%h load=%h pc=%h alu=%h req_addr=%h want all 0",
                bus.wb_addr, bus.load_data, bus.pc_data, bus.alu_data, bus.mem_req_addr);
        end
        n_checks++;
        if (bus.issue_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b want 1", bus.issue_ready);
        end
        rstn = 1'b1;
        bus.issue_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ((bus.wb_alu | bus.busy) !== 1'b0) begin
            n_fail++; $display("FAIL reset_no_accept: wb_alu=%b busy=%b want 0 0", bus.wb_alu, bus.busy);
        end
    endtask

    task automatic test_alu();
        run_txn(2'b00, 5'd5, 64'h1234, 64'h0, 64'h0, 3'b000, 0, 0, 64'h0);
        n_checks++;
        if (obs_timeout || obs_wb_cnt != 1) begin
            n_fail++; $display("FAIL alu_wb_count: got %0d timeout=%0b want 1", obs_wb_cnt, obs_timeout);
        end
        n_checks++;
        if ({obs_wb_en, obs_wb_alu, obs_wb_pc, obs_wb_load} !== 4'b1100 || obs_wb_addr !== 5'd5 || obs_alu_data !== 64'h1234) begin
            n_fail++; $display("FAIL alu_wb_fields: en/alu/pc/load=%b addr=%0d alu=%h want 1100 5 1234",
                {obs_wb_en, obs_wb_alu, obs_wb_pc, obs_wb_load}, obs_wb_addr, obs_alu_data);
        end
        n_checks++;
        if (obs_req_cycles != 0 || obs_err != 0 || obs_stray) begin
            n_fail++; $display("FAIL alu_side_effects: req=%0d err=%0d stray=%0b want 0 0 0", obs_req_cycles, obs_err, obs_stray);
        end
    endtask

    task automatic test_lb_delayed();
        run_txn(2'b10, 5'd9, 64'h0, 64'h0, 64'h1003, 3'b000, 2, 1, 64'h0000_0000_8000_0000);
        n_checks++;
        if (obs_req_addr !== 64'h1000 || obs_req_cycles != 3 || !obs_addr_stable) begin
            n_fail++; $display("FAIL lb_request: addr=%h cycles=%0d stable=%0b want 1000 3 1", obs_req_addr, obs_req_cycles, obs_addr_stable);
        end
        n_checks++;
        if (obs_timeout || obs_wb_cnt != 1 || obs_load_data !== 64'hFFFF_FFFF_FFFF_FF80 || !obs_wb_load || !obs_wb_en || obs_wb_addr !== 5'd9) begin
            n_fail++; $display("FAIL lb_data: data=%h wb_cnt=%0d load=%b en=%b addr=%0d want ffffffffffffff80 1 1 1 9",
                obs_load_data, obs_wb_cnt, obs_wb_load, obs_wb_en, obs_wb_addr);
        end
    endtask

    task automatic test_lwu();
        run_txn(2'b10, 5'd12, 64'h0, 64'h0, 64'h2004, 3'b110, 0, 0, 64'hDEAD_BEEF_0000_0000);
        n_checks++;
        if (obs_timeout || obs_load_data !== 64'h0000_0000_DEAD_BEEF || obs_wb_load !== 1'b1 || obs_onehot_bad) begin
            n_fail++; $display("FAIL lwu_data: data=%h wb_load=%b onehot_bad=%b want 00000000deadbeef 1 0",
                obs_load_data, obs_wb_load, obs_onehot_bad);
        end
    endtask

    task automatic test_misaligned_ld();
        run_txn(2'b10, 5'd4, 64'h0, 64'h0, 64'h3004, 3'b011, 0, 0, 64'h0);
        n_checks++;
        if (obs_err != 1 || obs_stray) begin
            n_fail++; $display("FAIL ld_err_pulse: pulses=%0d stray=%0b want 1 0", obs_err, obs_stray);
        end
        n_checks++;
        if (obs_req_cycles != 0 || obs_wb_cnt != 0 || obs_ready_low) begin
            n_fail++; $display("FAIL ld_no_activity: req=%0d wb=%0d ready_low=%0b want 0 0 0", obs_req_cycles, obs_wb_cnt, obs_ready_low);
        end
    endtask

    task automatic test_pc_rd0();
        run_txn(2'b01, 5'd0, 64'h0, 64'h8000_0044, 64'h0, 3'b000, 0, 0, 64'h0);
        n_checks++;
        if (obs_timeout || obs_wb_cnt != 1 || {obs_wb_pc, obs_wb_en} !== 2'b10 || obs_pc_data !== 64'h8000_0044) begin
            n_fail++; $display("FAIL pc_rd0: wb_cnt=%0d pc/en=%b pc_data=%h want 1 10 80000044",
                obs_wb_cnt, {obs_wb_pc, obs_wb_en}, obs_pc_data);
        end
    endtask

    task automatic test_reset_in_wait();
        int wb_seen;
        wb_seen = 0;
        @(negedge clk);
        bus.issue_valid = 1'b1; bus.issue_kind = 2'b10; bus.issue_rd = 5'd7;
        bus.issue_addr = 64'h4000; bus.issue_funct3 = 3'b011;
        @(negedge clk);
        bus.issue_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        n_checks++;
        if ({bus.busy, bus.mem_req_valid} !== 2'b10) begin
            n_fail++; $display("FAIL rst_wait_reached: busy/req=%b want 10", {bus.busy, bus.mem_req_valid});
        end
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 64'h1122_3344_5566_7788;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.wb_en | bus.wb_load | bus.wb_pc | bus.wb_alu) wb_seen++;
            if (i != 3) @(negedge clk);
        end
        n_checks++;
        if (wb_seen != 0) begin
            n_fail++; $display("FAIL rst_wait_no_wb: got %0d wb cycles want 0", wb_seen);
        end
        n_checks++;
        if ({bus.busy, bus.err, bus.mem_req_valid} !== 3'b000 || bus.issue_ready !== 1'b1 ||
            {bus.wb_addr, bus.load_data, bus.pc_data, bus.alu_data, bus.mem_req_addr} !== '0) begin
            n_fail++; $display("FAIL rst_wait_outputs: busy/err/req=%b ready=%b load=%h req_addr=%h want 000 1 0 0",
                {bus.busy, bus.err, bus.mem_req_valid}, bus.issue_ready, bus.load_data, bus.mem_req_addr);
        end
    endtask

    task automatic test_random();
        logic [1:0]    kind;
        logic [2:0]    f3;
        logic [AW-1:0] rd;
        logic [DW-1:0] addr, alu, pc, rsp, exp_data;
        int            rq, rs;
        bit            bad;
        for (int it = 0; it < 40; it++) begin
            kind = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) kind = 2'b10;
            f3   = 3'($urandom_range(0, 7));
            rd   = AW'($urandom);
            addr = {$urandom, $urandom};
            alu  = {$urandom, $urandom};
            pc   = {$urandom, $urandom};
            rsp  = {$urandom, $urandom};
            rq   = int'($urandom_range(0, 3));
            rs   = int'($urandom_range(0, 3));
            bad  = model_bad(kind, f3, addr[2:0]);
            run_txn(kind, rd, alu, pc, addr, f3, rq, rs, rsp);
            n_checks++;
            if (obs_timeout || obs_stray || obs_err != (bad ? 1 : 0) || obs_wb_cnt != (bad ? 0 : 1)) begin
                n_fail++; $display("FAIL rand_flow[%0d]: kind=%0d f3=%0d off=%0d err=%0d wb=%0d stray=%0b timeout=%0b want err=%0d wb=%0d",
                    it, kind, f3, addr[2:0], obs_err, obs_wb_cnt, obs_stray, obs_timeout, bad ? 1 : 0, bad ? 0 : 1);
            end
            if (!bad) begin
                n_checks++;
                if (obs_wb_en !== (rd != 0) || obs_wb_addr !== rd || obs_onehot_bad ||
                    {obs_wb_load, obs_wb_pc, obs_wb_alu} !== {kind == 2'b10, kind == 2'b01, kind == 2'b00}) begin
                    n_fail++; $display("FAIL rand_strobes[%0d]: en=%b addr=%0d load/pc/alu=%b for kind=%0d rd=%0d",
                        it, obs_wb_en, obs_wb_addr, {obs_wb_load, obs_wb_pc, obs_wb_alu}, kind, rd);
                end
                n_checks++;
                if (kind == 2'b10) begin
                    exp_data = model_load(f3, addr[2:0], rsp);
                    if (obs_load_data !== exp_data || obs_req_addr !== {addr[DW-1:3], 3'b000} ||
                        obs_req_cycles != rq + 1 || !obs_addr_stable) begin
                        n_fail++; $display("FAIL rand_load[%0d]: data=%h want %h req_addr=%h want %h req_cycles=%0d want %0d",
                            it, obs_load_data, exp_data, obs_req_addr, {addr[DW-1:3], 3'b000}, obs_req_cycles, rq + 1);
                    end
                end else if (kind == 2'b01) begin
                    if (obs_pc_data !== pc || obs_req_cycles != 0) begin
                        n_fail++; $display("FAIL rand_pc[%0d]: pc_data=%h want %h req=%0d", it, obs_pc_data, pc, obs_req_cycles);
                    end
                end else begin
                    if (obs_alu_data !== alu || obs_req_cycles != 0) begin
                        n_fail++; $display("FAIL rand_alu[%0d]: alu_data=%h want %h req=%0d", it, obs_alu_data, alu, obs_req_cycles);
                    end
                end
            end
        end
    endtask

    initial begin
        idle_inputs();
        rstn = 1'b0;
        test_reset();
        test_alu();
        test_lb_delayed();
        test_lwu();
        test_misaligned_ld();
        test_pc_rd0();
        test_reset_in_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
